// File: rtl/buffered_fanout_tree_if.sv
// Handshake bundle for buffered_fanout_tree: one source stream in, NUM_LOADS
// independent ready/valid branches out, plus occupancy and accept count.
interface buffered_fanout_tree_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic [NUM_LOADS-1:0]         in_mask;
  logic                         in_ready;
  logic [NUM_LOADS-1:0]         out_valid;
  logic [NUM_LOADS*WIDTH-1:0]   out_data;
  logic [NUM_LOADS-1:0]         out_ready;
  logic [NUM_LOADS*OCC_W-1:0]   occ;
  logic [CNT_W-1:0]             accepted_cnt;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, occ, accepted_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, occ, accepted_cnt
  );
endinterface

// File: rtl/buffered_fanout_tree.sv
// Broadcast fanout stage: each accepted word is copied into a small FIFO per
// enabled load branch so a stalled consumer only stalls the shared input.
module buffered_fanout_tree #(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  buffered_fanout_tree_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(1'b0);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [NUM_LOADS-1:0] blocking_s;
  logic                 accept_s;
  logic [CNT_W-1:0]     cnt_r;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.in_ready     = ~(|blocking_s);
  assign accept_s         = bus.in_valid & bus.in_ready;
  assign bus.accepted_cnt = cnt_r;

  // Accepted-word counter, wraps naturally; zero-mask accepts count too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  for (genvar g = 0; g < NUM_LOADS; g++) begin : g_branch
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [OCC_W-1:0] rem_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             push_s;
    logic             pop_s;

    assign blocking_s[g] = bus.in_mask[g] & (occ_r == OCC_FULL);

    // Next occupancy and next head word; the head is kept in its own register
    // so out_data is registered and holds its last value while empty.
    always_comb begin
      push_s     = accept_s & bus.in_mask[g];
      pop_s      = (occ_r != OCC_ZERO) & bus.out_ready[g];
      rd_nxt_s   = rd_ptr_r;
      rem_s      = occ_r;
      occ_nxt_s  = occ_r;
      head_nxt_s = head_r;
      if (pop_s) begin
        rd_nxt_s = rd_ptr_r + PTR_ONE;
        rem_s    = occ_r - OCC_ONE;
      end else begin
        rd_nxt_s = rd_ptr_r;
        rem_s    = occ_r;
      end
      if (push_s) begin
        occ_nxt_s = rem_s + OCC_ONE;
      end else begin
        occ_nxt_s = rem_s;
      end
      if (push_s && (rem_s == OCC_ZERO)) begin
        head_nxt_s = bus.in_data;
      end else if (rem_s != OCC_ZERO) begin
        head_nxt_s = mem_r[rd_nxt_s];
      end else begin
        head_nxt_s = head_r;
      end
    end

    // Branch storage; deliberately not reset.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.in_data;
      end
    end

    // Branch pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        occ_r    <= OCC_ZERO;
        head_r   <= {WIDTH{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        rd_ptr_r <= rd_nxt_s;
        occ_r    <= occ_nxt_s;
        head_r   <= head_nxt_s;
      end
    end

    assign bus.out_valid[g]                 = (occ_r != OCC_ZERO);
    assign bus.out_data[g*WIDTH +: WIDTH]   = head_r;
    assign bus.occ[g*OCC_W +: OCC_W]        = occ_r;
  end
endmodule

// File: tb/tb_buffered_fanout_tree.sv
// Bench for buffered_fanout_tree: table-driven stimulus with a per-branch
// scoreboard, plus hand sequences for async reset and counter wrap.
module tb_buffered_fanout_tree;
  localparam int WIDTH = 8;
  localparam int NL    = 4;
  localparam int DEPTH = 2;
  localparam int OW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffered_fanout_tree_if #(.WIDTH(WIDTH), .NUM_LOADS(NL), .DEPTH(DEPTH), .CNT_W(16)) bus ();
  buffered_fanout_tree_if #(.WIDTH(WIDTH), .NUM_LOADS(NL), .DEPTH(DEPTH), .CNT_W(4))  sbus ();

  buffered_fanout_tree #(.WIDTH(WIDTH), .NUM_LOADS(NL), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  buffered_fanout_tree #(.WIDTH(WIDTH), .NUM_LOADS(NL), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] m;
    logic [3:0] r;
    logic       rdy;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] q[NL][$];
  int         mocc[NL];
  logic [15:0] mcnt;
  bit         mon_en = 1'b0;
  int         n_vec  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [3:0] m,
                     input logic [3:0] r, input logic rdy);
    vec_t e;
    e.v = v; e.d = d; e.m = m; e.r = r; e.rdy = rdy;
    tbl.push_back(e);
  endtask

  // Scoreboard: compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic er;
      logic acc;
      er = 1'b1;
      for (int i = 0; i < NL; i++)
        if (bus.in_mask[i] && mocc[i] == DEPTH) er = 1'b0;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
      for (int i = 0; i < NL; i++) begin
        chk($sformatf("occ%0d", i), {30'd0, bus.occ[i*OW +: OW]}, mocc[i]);
        chk($sformatf("out_valid%0d", i), {31'd0, bus.out_valid[i]}, {31'd0, mocc[i] != 0});
        if (mocc[i] != 0)
          chk($sformatf("out_data%0d", i), {24'd0, bus.out_data[i*WIDTH +: WIDTH]}, {24'd0, q[i][0]});
      end
      chk("accepted_cnt", {16'd0, bus.accepted_cnt}, {16'd0, mcnt});
      acc = bus.in_valid & er;
      for (int i = 0; i < NL; i++) begin
        if (mocc[i] != 0 && bus.out_ready[i]) begin
          void'(q[i].pop_front());
          mocc[i]--;
        end
        if (acc && bus.in_mask[i]) begin
          q[i].push_back(bus.in_data);
          mocc[i]++;
        end
      end
      if (acc) mcnt = mcnt + 16'd1;
    end
  end

  initial begin
    mcnt = 16'd0;
    for (int i = 0; i < NL; i++) mocc[i] = 0;
    bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.in_mask = 4'h0;  bus.out_ready = 4'h0;
    sbus.in_valid = 1'b0; sbus.in_data = 8'h00; sbus.in_mask = 4'h1; sbus.out_ready = 4'hF;

    // broadcast
    add(1'b1, 8'h11, 4'hF, 4'hF, 1'b1);
    add(1'b1, 8'h22, 4'hF, 4'hF, 1'b1);
    add(1'b1, 8'h33, 4'hF, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'hF, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'hF, 4'hF, 1'b1);
    // back-pressure on branch 2
    add(1'b1, 8'hA0, 4'hF, 4'hB, 1'b1);
    add(1'b1, 8'hA1, 4'hF, 4'hB, 1'b1);
    add(1'b1, 8'hA2, 4'hF, 4'hB, 1'b0);
    add(1'b1, 8'hA2, 4'hF, 4'hB, 1'b0);
    add(1'b1, 8'hA2, 4'hF, 4'hF, 1'b0);
    add(1'b1, 8'hA2, 4'hF, 4'hB, 1'b1);
    // full branch 2 masked off
    add(1'b1, 8'h5C, 4'h3, 4'hB, 1'b1);
    add(1'b0, 8'h00, 4'h0, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'h0, 4'hF, 1'b1);
    // zero mask
    add(1'b1, 8'h77, 4'h0, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'h0, 4'hF, 1'b1);
    // streaming with push and pop together on branch 0
    for (int k = 0; k < 16; k++) add(1'b1, k[7:0], 4'h1, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'h0, 4'hF, 1'b1);
    add(1'b0, 8'h00, 4'h0, 4'hF, 1'b1);

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("rst_occ", {24'd0, bus.occ}, 32'd0);
    chk("rst_cnt", {16'd0, bus.accepted_cnt}, 32'd0);
    chk("rst_small_cnt", {28'd0, sbus.accepted_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      bus.in_valid = tbl[i].v; bus.in_data = tbl[i].d;
      bus.in_mask = tbl[i].m;  bus.out_ready = tbl[i].r;
      #2 chk($sformatf("tbl_in_ready[%0d]", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
    end
    @(posedge clk); #1;
    chk("cnt_total", {16'd0, bus.accepted_cnt}, 32'd24);

    // async reset while every branch holds a word
    bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.in_mask = 4'hF; bus.out_ready = 4'h0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("arst_occ", {24'd0, bus.occ}, 32'd0);
    chk("arst_cnt", {16'd0, bus.accepted_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < NL; i++) begin
      q[i].delete();
      mocc[i] = 0;
    end
    mcnt = 16'd0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'hBE; bus.in_mask = 4'hF; bus.out_ready = 4'hF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("post_rst_valid", {28'd0, bus.out_valid}, 32'hF);
    chk("post_rst_data0", {24'd0, bus.out_data[7:0]}, 32'hBE);
    @(posedge clk); @(posedge clk); #1;

    // 4-bit counter wraps after 16 accepts
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      if (k == 16) chk("small_cnt16", {28'd0, sbus.accepted_cnt}, 32'd0);
      sbus.in_valid = 1'b1;
      sbus.in_data = k[7:0];
      #1 chk("small_in_ready", {31'd0, sbus.in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    chk("small_cnt17", {28'd0, sbus.accepted_cnt}, 32'd1);
    chk("small_occ0", {30'd0, sbus.occ[1:0]}, 32'd1);
    chk("small_head", {24'd0, sbus.out_data[7:0]}, 32'h10);
    @(posedge clk); #1;

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/buffered_fanout_tree.md
# buffered_fanout_tree

Parametrised broadcast fanout stage: one driver stream is replicated to NUM_LOADS load branches, and each branch has its own FIFO repeater buffer. This is the sequential successor to the single-net buffer-before-load structure. It adds per-branch back-pressure, a per-word load-enable mask and an accepted-word counter. It sits between a single high-fanout producer and independent consumers, so that one slow load cannot corrupt data for the others.

## Interface
- WIDTH, 8, data bits per word.
- NUM_LOADS, 4, number of load branches; legal range 1..16.
- DEPTH, 2, entries per branch FIFO; must be a power of two and at least 2.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source word present.
- in_data  in  WIDTH  source word.
- in_mask  in  NUM_LOADS  branches that receive this word; bit i selects branch i.
- in_ready  out  1  word is accepted this cycle if in_valid is also high.
- out_valid  out  NUM_LOADS  branch i head entry valid.
- out_data  out  NUM_LOADS*WIDTH  branch i head word in bits [i*WIDTH +: WIDTH].
- out_ready  in  NUM_LOADS  branch i consumer takes its head entry.
- occ  out  NUM_LOADS*($clog2(DEPTH)+1)  per-branch occupancy.
- accepted_cnt  out  CNT_W  count of accepted words; wraps modulo 2^CNT_W.

## Operation
- Branch i is "blocking" when in_mask[i]=1 and occ_i==DEPTH (registered count).
- in_ready = 1 exactly when no branch is blocking. It is combinational from in_mask and registered occupancy only, never from out_ready. A pop in the same cycle does not free space for a push in that cycle.
- accept = in_valid & in_ready.
- On accept, in_data is written at the tail of every branch with in_mask[i]=1. Branches with in_mask[i]=0 are unchanged.
- An accept with in_mask all zero is legal: the word is discarded, and accepted_cnt still increments.
- pop_i = out_valid[i] & out_ready[i]. It advances the branch-i head.
- out_valid[i] = (occ_i != 0). out_data for branch i is the head entry. out_data is don't-care while out_valid[i]=0, but the implementation holds the last value with no X propagation.
- occ_i update: +1 on push only, -1 on pop only, unchanged on push and pop together. It never exceeds DEPTH and never goes below 0.
- Each branch has read/write pointers of $clog2(DEPTH) bits that wrap naturally. Ordering is strict FIFO per branch.
- Branches are fully independent apart from the shared in_ready.
- in_valid, in_data and in_mask must stay stable while in_valid=1 and in_ready=0. The block does not check this.
- accepted_cnt increments by 1 per accept and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, rst_n low):
  - all occ = 0, out_valid = 0, accepted_cnt = 0, pointers = 0.
  - in_ready = 1 during reset and after it.
  - FIFO storage is not reset.
- Reset mid-operation discards all buffered words immediately. The first edge after rst_n deassertion may accept a word.
- Latency: a word accepted at edge k appears on out_valid/out_data of an empty enabled branch after edge k, i.e. in cycle k+1. There is no combinational in-to-out path.
- Throughput: 1 word/cycle per branch when consumers keep out_ready=1.
- Full boundary:
  - Branch at DEPTH with out_ready=1 and an enabled input: in_ready=0 that cycle and the pop completes. in_ready=1 the next cycle.
  - A full branch that is masked off (in_mask[i]=0) does not block.
- Empty boundary: out_ready=1 with out_valid=0 has no effect.

## Test plan
- Broadcast:
  - Stimulus: WIDTH=8, NUM_LOADS=4, DEPTH=2; send 0x11, 0x22, 0x33 with mask 4'b1111, all out_ready=1.
  - Required: each branch outputs 0x11, 0x22, 0x33 on consecutive cycles, starting 1 cycle after each accept; accepted_cnt=3.
- Back-pressure:
  - Stimulus: hold out_ready[2]=0; send 0xA0, 0xA1, 0xA2 with mask 4'b1111.
  - Required: first two accepted; in_ready drops to 0 with occ_2=2; 0xA2 is held until out_ready[2]=1 for one cycle, then accepted one cycle later. Other branches see no duplicates.
- Masking:
  - Stimulus: branch 2 full; send 0x5C with mask 4'b0011.
  - Required: accepted immediately; only branches 0 and 1 receive 0x5C; occ_2 stays 2.
- Zero mask:
  - Stimulus: send 0x77 with mask 4'b0000.
  - Required: in_ready=1; no out_valid rises; accepted_cnt increments by 1.
- Simultaneous push/pop and wrap:
  - Stimulus: stream 0x00..0x0F with mask 4'b0001 and out_ready[0]=1; separately set CNT_W=4 and send 17 words.
  - Required: occ_0 stays 1 in steady state and pointers wrap with no data loss; accepted_cnt reads 1 after the 17th word.
- Async reset:
  - Stimulus: assert rst_n=0 between edges while branches hold data.
  - Required: out_valid, occ and accepted_cnt go to 0 immediately without a clock edge; in_ready=1; after release, the next word goes through with 1-cycle latency.
